// File: rtl/btn_event_decoder.sv
// Button event decoder: turns a debounced level into press/release/long/repeat/double-click pulses.
// Latency: every event is a registered pulse, updated on the clk edge that samples the causing btn_db_i value.
// Backpressure: none; pulses are single-cycle and must be consumed in the cycle they are high.
module btn_event_decoder #(
  parameter int unsigned      CNT_W         = 24,
  parameter logic [CNT_W-1:0] LONG_CYCLES   = CNT_W'(1_000_000),
  parameter logic [CNT_W-1:0] REPEAT_CYCLES = CNT_W'(250_000),
  parameter logic [CNT_W-1:0] GAP_CYCLES    = CNT_W'(500_000)
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_db_i,
  output logic press_o,
  output logic release_o,
  output logic long_press_o,
  output logic repeat_o,
  output logic double_click_o,
  output logic held_o
);

  // Thresholds are compared against the pre-increment count, so the last
  // count value before the event fires is the parameter minus one.
  localparam logic [CNT_W-1:0] LONG_LAST   = LONG_CYCLES - CNT_W'(1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_CYCLES - CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LAST    = GAP_CYCLES - CNT_W'(1);

  typedef enum logic [2:0] {
    LOCKOUT,
    IDLE,
    PRESSED,
    LONG_HELD,
    GAP,
    PRESSED2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;
  logic             release_q;
  logic             long_press_q;
  logic             repeat_q;
  logic             double_click_q;
  logic             held_q;

  // Whole decoder: state, shared hold/gap counter and registered event pulses.
  // The counter is cleared on every state change, so it can never wrap.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= LOCKOUT;
      cnt_q          <= '0;
      press_q        <= 1'b0;
      release_q      <= 1'b0;
      long_press_q   <= 1'b0;
      repeat_q       <= 1'b0;
      double_click_q <= 1'b0;
      held_q         <= 1'b0;
    end else begin
      // Pulses default low; each branch raises only what it fires.
      press_q        <= 1'b0;
      release_q      <= 1'b0;
      long_press_q   <= 1'b0;
      repeat_q       <= 1'b0;
      double_click_q <= 1'b0;

      case (state_q)
        // A button held through reset must be let go before it can count.
        LOCKOUT: begin
          held_q <= 1'b0;
          cnt_q  <= '0;
          if (!btn_db_i) begin
            state_q <= IDLE;
          end
        end

        IDLE: begin
          cnt_q <= '0;
          if (btn_db_i) begin
            state_q <= PRESSED;
            press_q <= 1'b1;
            held_q  <= 1'b1;
          end else begin
            held_q <= 1'b0;
          end
        end

        // First and second presses share hold timing; only the release
        // destination differs (a second press never opens another window).
        PRESSED, PRESSED2: begin
          if (!btn_db_i) begin
            // Release beats a coincident long-press threshold.
            release_q <= 1'b1;
            held_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= (state_q == PRESSED) ? GAP : IDLE;
          end else if (cnt_q == LONG_LAST) begin
            long_press_q <= 1'b1;
            held_q       <= 1'b1;
            cnt_q        <= '0;
            state_q      <= LONG_HELD;
          end else begin
            held_q <= 1'b1;
            cnt_q  <= cnt_q + CNT_W'(1);
          end
        end

        LONG_HELD: begin
          if (!btn_db_i) begin
            // After a long press there is no double-click window.
            release_q <= 1'b1;
            held_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else if (cnt_q == REPEAT_LAST) begin
            repeat_q <= 1'b1;
            held_q   <= 1'b1;
            cnt_q    <= '0;
          end else begin
            held_q <= 1'b1;
            cnt_q  <= cnt_q + CNT_W'(1);
          end
        end

        // A press sampled on the expiry cycle still counts as a double click.
        GAP: begin
          if (btn_db_i) begin
            press_q        <= 1'b1;
            double_click_q <= 1'b1;
            held_q         <= 1'b1;
            cnt_q          <= '0;
            state_q        <= PRESSED2;
          end else if (cnt_q == GAP_LAST) begin
            held_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            held_q <= 1'b0;
            cnt_q  <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          held_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= LOCKOUT;
        end
      endcase
    end
  end

  assign press_o        = press_q;
  assign release_o      = release_q;
  assign long_press_o   = long_press_q;
  assign repeat_o       = repeat_q;
  assign double_click_o = double_click_q;
  assign held_o         = held_q;

endmodule
